// File: rtl/ssa_pkg.sv
// rtl/ssa_pkg.sv - shared state encoding and default widths for the signature analyzer
package ssa_pkg;

    // Default signature width and bit-count width.
    localparam int SSA_N_DEFAULT  = 8;
    localparam int SSA_CW_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ssa_state_e;

endpackage

// File: rtl/sisr_core.sv
// rtl/sisr_core.sv - n-bit Galois serial-input signature register (no control FSM)
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset (clears the register)
//   load       load seed into the register (wins over step)
//   seed       value loaded on load
//   step       perform one compaction step with sin
//   sin        serial response bit
//   poly       feedback taps for stages 0..n-2 (the top stage always takes fb)
//   sig        current signature
//   sig_next   signature after compacting sin into sig (combinational)
import ssa_pkg::*;

module sisr_core #(
    parameter int n = SSA_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [n-1:0] seed,
    input  logic         step,
    input  logic         sin,
    input  logic [n-2:0] poly,
    output logic [n-1:0] sig,
    output logic [n-1:0] sig_next
);

    logic fb;

    // Right-shifting Galois step: bit 0 leaves, mixes with sin, and is fed
    // back into the top stage and every tapped lower stage.
    always_comb begin
        fb       = sig[0] ^ sin;
        sig_next = '0;
        for (int i = 0; i < n - 1; i++) begin
            sig_next[i] = sig[i+1] ^ (fb & poly[i]);
        end
        sig_next[n-1] = fb;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (load) begin
            sig <= seed;
        end else if (step) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/ssa_signature_analyzer.sv
// rtl/ssa_signature_analyzer.sv - BIST response compactor with session control and golden compare
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   start       pulse: latch poly/golden/len, load seed, begin a session
//   en, sin     serial response bit and its valid strobe
//   poly        feedback polynomial (bit n-1 unused)
//   seed        initial signature
//   golden      expected final signature
//   len         number of response bits in the session
//   busy        high while compacting
//   done        high once the session has finished, until next start
//   pass        final signature matched golden (valid while done)
//   signature   current signature register
//   bit_cnt     bits compacted so far
import ssa_pkg::*;

module ssa_signature_analyzer #(
    parameter int n  = SSA_N_DEFAULT,
    parameter int CW = SSA_CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          en,
    input  logic          sin,
    input  logic [n-1:0]  poly,
    input  logic [n-1:0]  seed,
    input  logic [n-1:0]  golden,
    input  logic [CW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [n-1:0]  signature,
    output logic [CW-1:0] bit_cnt
);

    ssa_state_e    state;
    logic [n-2:0]  poly_q;
    logic [n-1:0]  golden_q;
    logic [CW-1:0] len_q;
    logic [CW-1:0] cnt_inc;
    logic [n-1:0]  sig_next;
    logic          core_step;

    // The top polynomial bit has no effect on the Galois step.
    logic poly_msb_unused;
    assign poly_msb_unused = poly[n-1];

    assign cnt_inc = bit_cnt + {{(CW-1){1'b0}}, 1'b1};

    // start outranks en, so the bit presented alongside start is dropped.
    assign core_step = (state == ST_RUN) && en && !start;

    sisr_core #(
        .n(n)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (start),
        .seed     (seed),
        .step     (core_step),
        .sin      (sin),
        .poly     (poly_q),
        .sig      (signature),
        .sig_next (sig_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            poly_q   <= '0;
            golden_q <= '0;
            len_q    <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else if (start) begin
            poly_q   <= poly[n-2:0];
            golden_q <= golden;
            len_q    <= len;
            bit_cnt  <= '0;
            if (len == '0) begin
                // Empty session: the seed itself is the final signature.
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (seed == golden);
            end else begin
                state <= ST_RUN;
                busy  <= 1'b1;
                done  <= 1'b0;
                pass  <= 1'b0;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    if (en) begin
                        bit_cnt <= cnt_inc;
                        if (cnt_inc == len_q) begin
                            // Compare against the value being written this
                            // edge so pass lines up with done.
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (sig_next == golden_q);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ssa_signature_analyzer.sv
// tb/tb_ssa_signature_analyzer.sv - scoreboard bench for ssa_signature_analyzer (n=4 and n=8 instances)
module tb_ssa_signature_analyzer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start4, start8, en, sin;
    logic [7:0]  poly, seed, golden;
    logic [15:0] len;

    logic        busy4, done4, pass4, busy8, done8, pass8;
    logic [3:0]  sig4;
    logic [7:0]  sig8;
    logic [15:0] cnt4, cnt8;

    ssa_signature_analyzer #(.n(4), .CW(16)) u4 (
        .clk(clk), .rst(rst), .start(start4), .en(en), .sin(sin),
        .poly(poly[3:0]), .seed(seed[3:0]), .golden(golden[3:0]), .len(len),
        .busy(busy4), .done(done4), .pass(pass4), .signature(sig4), .bit_cnt(cnt4)
    );

    ssa_signature_analyzer #(.n(8), .CW(16)) u8 (
        .clk(clk), .rst(rst), .start(start8), .en(en), .sin(sin),
        .poly(poly), .seed(seed), .golden(golden), .len(len),
        .busy(busy8), .done(done8), .pass(pass8), .signature(sig8), .bit_cnt(cnt8)
    );

    typedef struct {
        logic [7:0]  sig;
        logic [15:0] cnt;
        logic        pass;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];
    logic bits_q[$];
    logic gaps_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference Galois step, independent of the DUT.
    function automatic logic [7:0] model_step(input logic [7:0] s, input logic b,
                                              input logic [7:0] p, input int nb);
        logic       fb;
        logic [7:0] r;
        fb = s[0] ^ b;
        r  = 8'h00;
        for (int i = 0; i < nb - 1; i++) r[i] = s[i+1] ^ (fb & p[i]);
        r[nb-1] = fb;
        return r;
    endfunction

    function automatic logic [7:0] cur_sig(input int w);
        return (w == 4) ? {4'h0, sig4} : sig8;
    endfunction
    function automatic logic [15:0] cur_cnt(input int w);
        return (w == 4) ? cnt4 : cnt8;
    endfunction
    function automatic logic cur_busy(input int w);
        return (w == 4) ? busy4 : busy8;
    endfunction
    function automatic logic cur_done(input int w);
        return (w == 4) ? done4 : done8;
    endfunction
    function automatic logic cur_pass(input int w);
        return (w == 4) ? pass4 : pass8;
    endfunction

    // Scoreboard monitor: a session result is due whenever done rises, or
    // stays high across a start (back-to-back empty sessions).
    logic ls4 = 1'b0, ls8 = 1'b0, dp4 = 1'b0, dp8 = 1'b0;
    always @(posedge clk) begin
        ls4 <= start4;
        ls8 <= start8;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done4 && (!dp4 || ls4)) begin
                check_eq("sb4_pending", 32'(q4.size()), 32'd1);
                if (q4.size() != 0) begin
                    e = q4.pop_front();
                    check_eq("sb4_sig",  32'(sig4),  32'(e.sig[3:0]));
                    check_eq("sb4_cnt",  32'(cnt4),  32'(e.cnt));
                    check_eq("sb4_pass", 32'(pass4), 32'(e.pass));
                end
            end
            if (done8 && (!dp8 || ls8)) begin
                check_eq("sb8_pending", 32'(q8.size()), 32'd1);
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    check_eq("sb8_sig",  32'(sig8),  32'(e.sig));
                    check_eq("sb8_cnt",  32'(cnt8),  32'(e.cnt));
                    check_eq("sb8_pass", 32'(pass8), 32'(e.pass));
                end
            end
        end
        dp4 = done4;
        dp8 = done8;
    end

    // Fill the stimulus with nbits bits of v, MSB first; gap bit set inserts
    // an idle (en=0) cycle before that response bit.
    task automatic load_bits(input logic [31:0] v, input int nbits, input logic [31:0] gaps);
        bits_q.delete();
        gaps_q.delete();
        for (int i = 0; i < nbits; i++) begin
            bits_q.push_back(v[nbits-1-i]);
            gaps_q.push_back(gaps[nbits-1-i]);
        end
    endtask

    task automatic set_start(input int w, input logic v);
        if (w == 4) start4 = v;
        else start8 = v;
    endtask

    task automatic scramble_cfg(input logic [7:0] p, input logic [7:0] s, input logic [7:0] g);
        poly   = ~p;
        seed   = ~s;
        golden = ~g;
        len    = 16'h0003;
    endtask

    task automatic run_session(input int w, input logic [7:0] p, input logic [7:0] s,
                               input logic [7:0] g, input int nbits, input int abort_after);
        logic [7:0] m;
        logic [7:0] msk;
        exp_t       e;
        int         cyc;
        msk = (w == 4) ? 8'h0F : 8'hFF;
        m   = s & msk;
        for (int i = 0; i < nbits; i++) m = model_step(m, bits_q[i], p, w);
        e.sig  = m;
        e.cnt  = nbits[15:0];
        e.pass = (m == (g & msk));
        if (w == 4) q4.push_back(e);
        else q8.push_back(e);

        @(posedge clk); #1;
        poly = p; seed = s; golden = g; len = nbits[15:0];
        en = 1'b1; sin = 1'b1;
        set_start(w, 1'b1);
        @(posedge clk); #1;
        set_start(w, 1'b0);
        en = 1'b0;
        check_eq("start_sig",  32'(cur_sig(w)),  32'(s & msk));
        check_eq("start_cnt",  32'(cur_cnt(w)),  32'd0);
        check_eq("start_busy", 32'(cur_busy(w)), 32'(nbits != 0));
        check_eq("start_done", 32'(cur_done(w)), 32'(nbits == 0));
        scramble_cfg(p, s, g);

        if (abort_after > 0) begin
            for (int j = 0; j < abort_after; j++) begin
                en = 1'b1; sin = bits_q[j];
                @(posedge clk); #1;
                check_eq("pre_abort_cnt", 32'(cur_cnt(w)), 32'(j + 1));
            end
            poly = p; seed = s; golden = g; len = nbits[15:0];
            en = 1'b1; sin = ~sin;
            set_start(w, 1'b1);
            @(posedge clk); #1;
            set_start(w, 1'b0);
            en = 1'b0;
            check_eq("restart_sig",  32'(cur_sig(w)),  32'(s & msk));
            check_eq("restart_cnt",  32'(cur_cnt(w)),  32'd0);
            check_eq("restart_busy", 32'(cur_busy(w)), 32'd1);
            scramble_cfg(p, s, g);
        end

        m = s & msk;
        for (int i = 0; i < nbits; i++) begin
            if (gaps_q[i]) begin
                en = 1'b0; sin = ~bits_q[i];
                @(posedge clk); #1;
                check_eq("gap_sig", 32'(cur_sig(w)), 32'(m));
                check_eq("gap_cnt", 32'(cur_cnt(w)), 32'(i));
            end
            en = 1'b1; sin = bits_q[i];
            @(posedge clk); #1;
            m = model_step(m, bits_q[i], p, w);
            check_eq("step_sig", 32'(cur_sig(w)), 32'(m));
            check_eq("step_cnt", 32'(cur_cnt(w)), 32'(i + 1));
        end
        en = 1'b0;

        cyc = 0;
        while (!cur_done(w) && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("done_seen", 32'(cur_done(w)), 32'd1);
        check_eq("busy_off",  32'(cur_busy(w)), 32'd0);

        // Session frozen in DONE: en activity ignored.
        for (int k = 0; k < 3; k++) begin
            en = 1'b1; sin = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        en = 1'b0;
        check_eq("frozen_sig",  32'(cur_sig(w)),  32'(e.sig));
        check_eq("frozen_cnt",  32'(cur_cnt(w)),  32'(e.cnt));
        check_eq("frozen_pass", 32'(cur_pass(w)), 32'(e.pass));
        check_eq("frozen_done", 32'(cur_done(w)), 32'd1);
        @(negedge clk); #1;
        check_eq("sb_drained", 32'(q4.size() + q8.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] g8;
        logic [7:0] gm;
        rst = 1'b1; start4 = 1'b0; start8 = 1'b0; en = 1'b0; sin = 1'b0;
        poly = 8'h00; seed = 8'h00; golden = 8'h00; len = 16'h0000;
        #12;
        check_eq("rst_sig4",  32'(sig4),  32'd0);
        check_eq("rst_cnt4",  32'(cnt4),  32'd0);
        check_eq("rst_busy4", 32'(busy4), 32'd0);
        check_eq("rst_done4", 32'(done4), 32'd0);
        check_eq("rst_pass4", 32'(pass4), 32'd0);
        check_eq("rst_sig8",  32'(sig8),  32'd0);
        check_eq("rst_done8", 32'(done8), 32'd0);
        rst = 1'b0;

        // Stream 1,0,1,1 into n=4, poly 0011, seed 0: steps B, E, C, D.
        load_bits(32'hB, 4, 32'h0);
        run_session(4, 8'h03, 8'h00, 8'h0D, 4, 0);
        check_eq("t1_sig_D",  32'(sig4),  32'hD);
        check_eq("t1_pass",   32'(pass4), 32'd1);
        run_session(4, 8'h03, 8'h00, 8'h0C, 4, 0);
        check_eq("t1_fail",   32'(pass4), 32'd0);

        // Same stream with idle cycles interleaved.
        load_bits(32'hB, 4, 32'h5);
        run_session(4, 8'h03, 8'h00, 8'h0D, 4, 0);
        check_eq("gap_sig_D", 32'(sig4),  32'hD);
        check_eq("gap_cnt_4", 32'(cnt4),  32'd4);

        // Restart in RUN after two bits.
        load_bits(32'hB, 4, 32'h0);
        run_session(4, 8'h03, 8'h00, 8'h0D, 4, 2);
        check_eq("abort_sig_D", 32'(sig4),  32'hD);
        check_eq("abort_pass",  32'(pass4), 32'd1);

        // Empty sessions, back to back.
        load_bits(32'h0, 0, 32'h0);
        run_session(8, 8'h1D, 8'h5A, 8'h5A, 0, 0);
        check_eq("len0_pass", 32'(pass8), 32'd1);
        run_session(8, 8'h1D, 8'h5A, 8'h00, 0, 0);
        check_eq("len0_fail", 32'(pass8), 32'd0);

        // Asynchronous reset in the middle of a session.
        @(posedge clk); #1;
        poly = 8'h1D; seed = 8'hA5; golden = 8'h00; len = 16'd8;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en = 1'b1; sin = 1'(i & 1);
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_sig8",  32'(sig8),  32'd0);
        check_eq("arst_cnt8",  32'(cnt8),  32'd0);
        check_eq("arst_busy8", 32'(busy8), 32'd0);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            en = 1'b1; sin = 1'(~i & 1);
            @(posedge clk); #1;
        end
        en = 1'b0;
        check_eq("post_rst_sig8",  32'(sig8),  32'd0);
        check_eq("post_rst_cnt8",  32'(cnt8),  32'd0);
        check_eq("post_rst_busy8", 32'(busy8), 32'd0);
        check_eq("post_rst_done8", 32'(done8), 32'd0);

        // Loopback: generator with the same poly/seed drives 255 bits.
        bits_q.delete();
        gaps_q.delete();
        g8 = 8'h01;
        for (int i = 0; i < 255; i++) begin
            bits_q.push_back(g8[0]);
            gaps_q.push_back(1'b0);
            g8 = model_step(g8, 1'b0, 8'h1D, 8);
        end
        gm = 8'h01;
        for (int i = 0; i < 255; i++) gm = model_step(gm, bits_q[i], 8'h1D, 8);
        run_session(8, 8'h1D, 8'h01, gm, 255, 0);
        check_eq("loop_pass", 32'(pass8), 32'd1);
        check_eq("loop_sig",  32'(sig8),  32'(gm));
        bits_q[100] = ~bits_q[100];
        run_session(8, 8'h1D, 8'h01, gm, 255, 0);
        check_eq("loop_flip_pass", 32'(pass8), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
